// File: rtl/alu_multibyte_seq.sv
// Byte-serial sequencer around an 8-bit ALU: LSB first, carry chained, result after BYTES+1 cycles.
// Optional registered `zero` flag output is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_multibyte_seq #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [8*BYTES-1:0] opa,
  input  logic [8*BYTES-1:0] opb,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] result,
  output logic               cout,
  output logic [80:0]        alu_oper,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic               alu_cin,
  input  logic [7:0]         alu_sum,
  input  logic               alu_cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic               zero
`endif
);

  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  localparam logic [80:0] S_AND   = 81'("and");
  localparam logic [80:0] S_ABS   = 81'("abstract");
  localparam logic [80:0] S_ABSA  = 81'("abstract_a");
  localparam logic [80:0] S_OR    = 81'("or_ab");
  localparam logic [80:0] S_ANDAB = 81'("and_ab");
  localparam logic [80:0] S_NOT   = 81'("not_ab");
  localparam logic [80:0] S_XOR   = 81'("exor");
  localparam logic [80:0] S_XNOR  = 81'("exnor");

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [8*BYTES-1:0] a_r, b_r, shadow, shadow_nxt;
  logic [2:0]         op_r;
  logic               cin_r, cr;
  logic [IW-1:0]      idx;

  // The last byte lands in shadow on the same edge that enters DONE, so result takes the merged value.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[8*idx +: 8] = alu_sum;
  end

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_oper = S_OR;
    if (state == RUN) begin
      alu_a = a_r[8*idx +: 8];
      alu_b = b_r[8*idx +: 8];
      case (op_r)
        3'd0:    alu_oper = S_AND;
        3'd1:    alu_oper = S_ABS;
        3'd2:    alu_oper = S_ABSA;
        3'd3:    alu_oper = S_OR;
        3'd4:    alu_oper = S_ANDAB;
        3'd5:    alu_oper = S_NOT;
        3'd6:    alu_oper = S_XOR;
        default: alu_oper = S_XNOR;
      endcase
      if (idx == '0) begin
        alu_cin = cin_r;
      end else begin
        // The ALU inverts carry-in for reverse subtract, so pre-invert to keep the chain correct.
        case (op_r)
          3'd0, 3'd1: alu_cin = cr;
          3'd2:       alu_cin = ~cr;
          default:    alu_cin = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      idx    <= '0;
      shadow <= '0;
      cr     <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      cin_r  <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= opa;
            b_r   <= opb;
            op_r  <= op;
            cin_r <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          shadow <= shadow_nxt;
          cr     <= alu_cout;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= shadow_nxt;
            cout   <= (op_r < 3'd3) ? alu_cout : 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero   <= ~|shadow_nxt;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq (BYTES=4) with a behavioural 8-bit ALU and a full-width reference model.
module tb_alu_multibyte_seq;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;
  localparam int NB    = BYTES + 2;

  localparam logic [80:0] N_AND   = 81'("and");
  localparam logic [80:0] N_ABS   = 81'("abstract");
  localparam logic [80:0] N_ABSA  = 81'("abstract_a");
  localparam logic [80:0] N_OR    = 81'("or_ab");
  localparam logic [80:0] N_ANDAB = 81'("and_ab");
  localparam logic [80:0] N_NOT   = 81'("not_ab");
  localparam logic [80:0] N_XOR   = 81'("exor");
  localparam logic [80:0] N_XNOR  = 81'("exnor");

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, cin;
  logic [2:0]    op;
  logic [W-1:0]  opa, opb;
  logic          busy, done, cout;
  logic [W-1:0]  result;
  logic [80:0]   alu_oper;
  logic [7:0]    alu_a, alu_b, alu_sum;
  logic          alu_cin, alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic          zero;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_res = '0;
  logic         exp_cout = 1'b0;

  alu_multibyte_seq #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  // Behavioural 8-bit ALU; logic ops deliberately drive carry-out high.
  logic [8:0] alu_t;
  always_comb begin
    alu_t = 9'bx;
    case (alu_oper)
      N_AND:   alu_t = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      N_ABS:   alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'(alu_cin);
      N_ABSA:  alu_t = {1'b0, ~alu_a} + {1'b0, alu_b} + 9'(!alu_cin);
      N_OR:    alu_t = {1'b1, alu_a | alu_b};
      N_ANDAB: alu_t = {1'b1, alu_a & alu_b};
      N_NOT:   alu_t = {1'b1, ~(alu_a & alu_b)};
      N_XOR:   alu_t = {1'b1, alu_a ^ alu_b};
      N_XNOR:  alu_t = {1'b1, ~(alu_a ^ alu_b)};
      default: alu_t = 9'bx;
    endcase
    alu_sum  = alu_t[7:0];
    alu_cout = alu_t[8];
  end

  function automatic logic [80:0] op_name(input logic [2:0] o);
    case (o)
      3'd0: return N_AND;
      3'd1: return N_ABS;
      3'd2: return N_ABSA;
      3'd3: return N_OR;
      3'd4: return N_ANDAB;
      3'd5: return N_NOT;
      3'd6: return N_XOR;
      default: return N_XNOR;
    endcase
  endfunction

  // Returns {cout, result} computed on the whole operand width.
  function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c);
    logic [W:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (o)
      3'd0: return ea + eb + (W+1)'(c);
      3'd1: return ea + {1'b0, ~b} + (W+1)'(c);
      3'd2: return {1'b0, ~a} + eb + (W+1)'(!c);
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, ~(a & b)};
      3'd6: return {1'b0, a ^ b};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  // Carry the ALU must receive for byte i: the carry out of the low i bytes of the wide operation.
  function automatic logic exp_cin(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input int i);
    logic [W:0] m, s;
    if (i == 0) return c;
    m = ((W+1)'(1) << (8*i)) - (W+1)'(1);
    case (o)
      3'd0: begin s = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(c);  return s[8*i];  end
      3'd1: begin s = ({1'b0, a} & m) + ({1'b0, ~b} & m) + (W+1)'(c); return s[8*i];  end
      3'd2: begin s = ({1'b0, ~a} & m) + ({1'b0, b} & m) + (W+1)'(!c); return ~s[8*i]; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'd0; opa = $urandom; opb = $urandom; cin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (alu_oper !== N_OR) begin failures++; $display("FAIL reset_oper got=%s exp=or_ab", alu_oper); end
    checks++; if ({alu_a, alu_b, alu_cin} !== 17'd0) begin
      failures++; $display("FAIL reset_alu_drive got=%h/%h/%b exp=0", alu_a, alu_b, alu_cin); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero); end
`endif
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_dropped busy=%b exp=0", busy); end
  endtask

  task automatic test_arith_logic();
    logic [2:0]   dop [4] = '{3'd0, 3'd1, 3'd2, 3'd6};
    logic [W-1:0] da  [4] = '{32'h00FFFFFF, 32'h00000000, 32'h00000001, 32'hA5A55A5A};
    logic [W-1:0] db  [4] = '{32'h00000001, 32'h00000001, 32'h00000010, 32'hFFFF0000};
    logic         dc  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] dr  [4] = '{32'h01000000, 32'hFFFFFFFF, 32'h0000000F, 32'h5A5A5A5A};
    logic         dco [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] o; logic [W-1:0] a, b, er; logic c, ec; logic [W:0] r;
    for (int n = 0; n < 44; n++) begin
      if (n < 4) begin
        o = dop[n]; a = da[n]; b = db[n]; c = dc[n]; er = dr[n]; ec = dco[n];
      end else begin
        o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; c = 1'($urandom);
        if (n % 5 == 0) b = ~a;
        r = ref_op(o, a, b, c); er = r[W-1:0]; ec = r[W];
      end
      start = 1'b1; op = o; opa = a; opb = b; cin = c;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); opa = $urandom; opb = $urandom; cin = 1'($urandom);
      for (int k = 1; k <= NB; k++) begin
        if (k > 1) @(negedge clk);
        checks++; if (busy !== (k <= BYTES + 1)) begin
          failures++; $display("FAIL busy n=%0d k=%0d got=%b", n, k, busy); end
        checks++; if (done !== (k == BYTES + 1)) begin
          failures++; $display("FAIL done n=%0d k=%0d got=%b", n, k, done); end
        if (k <= BYTES) begin
          checks++; if (alu_a !== a[8*(k-1) +: 8]) begin
            failures++; $display("FAIL alu_a n=%0d k=%0d got=%h exp=%h", n, k, alu_a, a[8*(k-1) +: 8]); end
          checks++; if (alu_b !== b[8*(k-1) +: 8]) begin
            failures++; $display("FAIL alu_b n=%0d k=%0d got=%h exp=%h", n, k, alu_b, b[8*(k-1) +: 8]); end
          checks++; if (alu_oper !== op_name(o)) begin
            failures++; $display("FAIL alu_oper n=%0d k=%0d got=%s exp=%s", n, k, alu_oper, op_name(o)); end
          checks++; if (alu_cin !== exp_cin(o, a, b, c, k - 1)) begin
            failures++; $display("FAIL alu_cin n=%0d k=%0d op=%0d got=%b exp=%b", n, k, o, alu_cin,
                                 exp_cin(o, a, b, c, k - 1)); end
          checks++; if (result !== exp_res || cout !== exp_cout) begin
            failures++; $display("FAIL result_hold n=%0d k=%0d got=%h/%b exp=%h/%b", n, k, result, cout,
                                 exp_res, exp_cout); end
        end else begin
          checks++; if (alu_oper !== N_OR || {alu_a, alu_b, alu_cin} !== 17'd0) begin
            failures++; $display("FAIL idle_drive n=%0d k=%0d oper=%s a=%h b=%h cin=%b", n, k, alu_oper,
                                 alu_a, alu_b, alu_cin); end
          checks++; if (result !== er) begin
            failures++; $display("FAIL result n=%0d op=%0d got=%h exp=%h", n, o, result, er); end
          checks++; if (cout !== ec) begin
            failures++; $display("FAIL cout n=%0d op=%0d got=%b exp=%b", n, o, cout, ec); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
          checks++; if (zero !== (er == '0)) begin
            failures++; $display("FAIL zero n=%0d got=%b exp=%b", n, zero, (er == '0)); end
`endif
        end
      end
      exp_res = er; exp_cout = ec;
    end
  endtask

  task automatic test_busy_start();
    logic [W-1:0] a, b; logic [W:0] r; int dn;
    a = $urandom; b = $urandom; r = ref_op(3'd0, a, b, 1'b1); dn = 0;
    start = 1'b1; op = 3'd0; opa = a; opb = b; cin = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= NB + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      start = (k == 2); op = 3'd1; opa = $urandom; opb = $urandom; cin = 1'b0;
    end
    checks++; if (dn !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dn); end
    checks++; if (result !== r[W-1:0] || cout !== r[W]) begin
      failures++; $display("FAIL busy_start_result got=%h/%b exp=%h/%b", result, cout, r[W-1:0], r[W]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle busy=%b exp=0", busy); end
    exp_res = r[W-1:0]; exp_cout = r[W];
  endtask

  task automatic test_reset_mid();
    int dn;
    start = 1'b1; op = 3'd0; opa = 32'h12345678; opb = 32'h11111111; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midrst_state busy=%b done=%b exp=0/0", busy, done); end
    checks++; if (result !== '0 || cout !== 1'b0) begin
      failures++; $display("FAIL midrst_result got=%h/%b exp=0/0", result, cout); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL midrst_zero got=%b exp=0", zero); end
`endif
    dn = 0;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++; if (dn !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dn); end
    start = 1'b1; op = 3'd0; opa = 32'hFFFFFFFF; opb = 32'h00000001; cin = 1'b0;
    @(posedge clk);
    dn = 0;
    for (int k = 1; k <= NB; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        dn++;
        checks++; if (result !== '0 || cout !== 1'b1) begin
          failures++; $display("FAIL wrap_result got=%h/%b exp=0/1", result, cout); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL wrap_zero got=%b exp=1", zero); end
`endif
      end
    end
    checks++; if (dn !== 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", dn); end
    exp_res = '0; exp_cout = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] so [3]; logic [W-1:0] sa [3], sb [3]; logic sc [3]; logic [W:0] sr [3];
    for (int j = 0; j < 3; j++) begin
      so[j] = 3'($urandom_range(0, 7)); sa[j] = $urandom; sb[j] = $urandom; sc[j] = 1'($urandom);
      sr[j] = ref_op(so[j], sa[j], sb[j], sc[j]);
    end
    for (int k = 0; k <= 3 * NB; k++) begin
      if (k > 0) begin
        checks++; if (busy !== (k % NB != 0)) begin
          failures++; $display("FAIL b2b_busy k=%0d got=%b", k, busy); end
        checks++; if (done !== (k % NB == NB - 1)) begin
          failures++; $display("FAIL b2b_done k=%0d got=%b", k, done); end
        if (k % NB == NB - 1) begin
          checks++; if (result !== sr[k / NB][W-1:0] || cout !== sr[k / NB][W]) begin
            failures++; $display("FAIL b2b_result k=%0d got=%h/%b exp=%h/%b", k, result, cout,
                                 sr[k / NB][W-1:0], sr[k / NB][W]); end
        end
      end
      start = (k <= 2 * NB);
      if (k % NB == 0 && k <= 2 * NB) begin
        op = so[k / NB]; opa = sa[k / NB]; opb = sb[k / NB]; cin = sc[k / NB];
      end else begin
        op = 3'($urandom); opa = $urandom; opb = $urandom; cin = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
    test_reset();
    test_arith_logic();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multibyte_seq.md
# alu_multibyte_seq

Multi-byte operation sequencer that sits directly upstream and downstream of the team's combinational 8-bit ALU. It accepts one BYTES-wide operation through a start/done handshake. Each cycle it feeds the ALU one byte, least-significant byte first, and propagates the carry between bytes. It captures each ALU byte result and presents the full-width result and final carry when the operation completes.

## Interface
- `BYTES`, default 4: operand width in bytes; legal range 2..8.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request an operation; sampled only in IDLE.
- `op`  in  3: operation code, see Operation.
- `opa`  in  8*BYTES: operand A.
- `opb`  in  8*BYTES: operand B.
- `cin`  in  1: carry-in applied to byte 0.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse in DONE.
- `result`  out  8*BYTES: last completed result.
- `cout`  out  1: last completed final carry.
- `alu_oper`  out  81: ASCII op-name string to the ALU, right-aligned, zero-padded.
- `alu_a`  out  8: ALU operand A byte.
- `alu_b`  out  8: ALU operand B byte.
- `alu_cin`  out  1: ALU carry-in.
- `alu_sum`  in  8: ALU byte result.
- `alu_cout`  in  1: ALU carry-out.

## Operation
- **op encoding:**
  - 0 = "and" (A+B+c).
  - 1 = "abstract" (A+~B+c).
  - 2 = "abstract_a" (~A+B+~c).
  - 3 = "or_ab".
  - 4 = "and_ab".
  - 5 = "not_ab".
  - 6 = "exor".
  - 7 = "exnor".
- **FSM:** IDLE -> RUN -> DONE -> IDLE.
- **IDLE:**
  - When `start`=1, latch `opa`, `opb`, `op` and `cin`, clear byte index `idx` to 0, and go to RUN.
  - When `start`=0, stay in IDLE.
- **RUN:**
  - Drive `alu_a` = opa byte[idx], `alu_b` = opb byte[idx], and `alu_oper` = string for the latched op (combinational from registers).
  - At each edge, write `alu_sum` into shadow byte[idx] and latch `alu_cout` into carry register `cr`; `idx` increments.
  - At `idx`=BYTES-1, go to DONE.
- **alu_cin, byte 0:** latched `cin`.
- **alu_cin, bytes 1..BYTES-1:**
  - ops 0/1: `cr`.
  - op 2: ~`cr`. The ALU inverts carry-in for this op, so inverting here keeps the chain arithmetically correct.
  - ops 3-7: 0.
- **DONE:** on entry, copy shadow to `result`. `cout` takes `cr` for ops 0-2 and 0 for ops 3-7. `done`=1 for this cycle only; next state IDLE.
- **Outside RUN:** `alu_a`=0, `alu_b`=0, `alu_cin`=0, `alu_oper`="or_ab". The ALU never sees an undefined op string.
- **start while busy:** ignored, no queuing. Inputs may change freely after the accepting edge.
- **Result stability:** `result` and `cout` change only at the edge entering DONE and hold until the next completion.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `result`=0, `cout`=0, `idx`=0, shadow=0, `cr`=0. ALU drive outputs take their idle values.
- **Latency:**
  - `start` sampled at edge T.
  - RUN occupies cycles T+1..T+BYTES.
  - `done`=1 and `result` valid in cycle T+BYTES+1.
  - Back in IDLE at T+BYTES+2.
  - Back-to-back throughput: one operation per BYTES+2 cycles.
- **busy:** rises in cycle T+1, falls at the edge entering IDLE.
- **Reset mid-operation:** `rst` has priority over all transitions. The FSM goes to IDLE at that edge with no `done` pulse, and `result`/`cout` return to 0.
- **Simultaneous `start` and `rst`:** reset wins; the start is dropped.
- **Wrap-around:** the final carry out of byte BYTES-1 appears only on `cout`; `result` wraps modulo 2^(8*BYTES).

## Configuration
- **`ALU_SEQ_ZERO_FLAG_EN` defined:** adds output `zero` (1 bit). It is registered at DONE entry together with `result`, and is 1 iff the new result is all zeros. Reset value 0; cleared by mid-operation reset.
- **`ALU_SEQ_ZERO_FLAG_EN` undefined:** the `zero` port and its logic are absent. All other behaviour is identical.

## Test plan
Bench instantiates the team's 8-bit ALU, with BYTES=4.
- **Add with carry ripple:** op 0, A=0x00FFFFFF, B=0x00000001, cin=0 -> `result`=0x01000000, `cout`=0. `done` at T+5 only, `busy` high T+1..T+5.
- **Subtract with borrow:** op 1, A=0x00000000, B=0x00000001, cin=1 -> `result`=0xFFFFFFFF, `cout`=0. With the macro defined, `zero`=0.
- **Reverse subtract, inverted chaining:** op 2, A=0x00000001, B=0x00000010, cin=0 -> `result`=0x0000000F, `cout`=1. Check `alu_cin`=0 on bytes 1-3.
- **Logical op:** op 6, A=0xA5A55A5A, B=0xFFFF0000 -> `result`=0x5A5A5A5A, `cout`=0. `alu_oper`="exor" during RUN and "or_ab" in IDLE.
- **start while busy:** pulse `start` with new operands at T+2. It is ignored: the result matches the first operation, and exactly one `done` pulse occurs.
- **Reset mid-run, then zero flag:**
  - Assert `rst` at T+3 -> IDLE next cycle, no `done`, `result`=0.
  - Then op 0, A=0xFFFFFFFF, B=0x00000001, cin=0 -> `result`=0, `cout`=1, `zero`=1 (with the macro defined).
